// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - retiring-instruction handshake from the memory stage into writeback
interface wb_stage_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic        is_load;
  logic        reg_dst;
  logic        mem_to_reg;
  logic [4:0]  imm_addr;
  logic [4:0]  reg_addr;
  logic [31:0] alu_data;

  modport master (
    output valid, we, is_load, reg_dst, mem_to_reg, imm_addr, reg_addr, alu_data,
    input  ready
  );

  modport slave (
    input  valid, we, is_load, reg_dst, mem_to_reg, imm_addr, reg_addr, alu_data,
    output ready
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage driving the 32x32 register file write port; WB_FWD_EN enables the forwarding outputs
module wb_stage (
  input  logic        clk,
  input  logic        rst_all,
  wb_stage_if.slave   up,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        wb_we,
  output logic        wb_reg_dst,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_imm_addr,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_alu_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data,
  output logic        load_wait
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched in_we of the held instruction; wb_we itself is only high in WRITE.
  logic        we_hold;
  logic        accept;

  logic        we_hold_nxt;
  logic        reg_dst_nxt;
  logic        mem_to_reg_nxt;
  logic [4:0]  imm_addr_nxt;
  logic [4:0]  reg_addr_nxt;
  logic [31:0] mem_data_nxt;
  logic [31:0] alu_data_nxt;
  logic [4:0]  res_addr_nxt;
  logic        wb_we_nxt;

  // Ready depends on state only, so there is no combinational path from valid.
  assign up.ready  = (state != WAIT_MEM);
  assign accept    = up.valid & up.ready & ~flush;
  assign load_wait = (state == WAIT_MEM);

  // State register
  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next contents of the held instruction
  always_comb begin
    state_nxt      = state;
    we_hold_nxt    = we_hold;
    reg_dst_nxt    = wb_reg_dst;
    mem_to_reg_nxt = wb_mem_to_reg;
    imm_addr_nxt   = wb_imm_addr;
    reg_addr_nxt   = wb_reg_addr;
    mem_data_nxt   = wb_mem_data;
    alu_data_nxt   = wb_alu_data;

    if (flush) begin
      // Kill wins over both a new accept and a returning load.
      state_nxt = EMPTY;
    end else begin
      case (state)
        WAIT_MEM: begin
          if (mem_rvalid) begin
            mem_data_nxt = mem_rdata;
            state_nxt    = WRITE;
          end
        end
        default: begin
          // EMPTY and WRITE behave alike: take a new instruction or drain.
          if (accept) begin
            we_hold_nxt    = up.we;
            reg_dst_nxt    = up.reg_dst;
            mem_to_reg_nxt = up.mem_to_reg;
            imm_addr_nxt   = up.imm_addr;
            reg_addr_nxt   = up.reg_addr;
            alu_data_nxt   = up.alu_data;
            mem_data_nxt   = 32'd0;
            state_nxt      = (up.we & up.is_load) ? WAIT_MEM : WRITE;
          end else begin
            state_nxt = EMPTY;
          end
        end
      endcase
    end

    // Same address mux as the register file; register 0 is never written.
    res_addr_nxt = reg_dst_nxt ? reg_addr_nxt : imm_addr_nxt;
    wb_we_nxt    = (state_nxt == WRITE) & we_hold_nxt & (res_addr_nxt != 5'd0);
  end

  // Held instruction fields and the registered write strobe
  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      we_hold       <= 1'b0;
      wb_we         <= 1'b0;
      wb_reg_dst    <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_imm_addr   <= 5'd0;
      wb_reg_addr   <= 5'd0;
      wb_mem_data   <= 32'd0;
      wb_alu_data   <= 32'd0;
    end else begin
      we_hold       <= we_hold_nxt;
      wb_we         <= wb_we_nxt;
      wb_reg_dst    <= reg_dst_nxt;
      wb_mem_to_reg <= mem_to_reg_nxt;
      wb_imm_addr   <= imm_addr_nxt;
      wb_reg_addr   <= reg_addr_nxt;
      wb_mem_data   <= mem_data_nxt;
      wb_alu_data   <= alu_data_nxt;
    end
  end

`ifdef WB_FWD_EN
  logic [31:0] res_data_nxt;

  // Same data mux as the register file: mem_to_reg selects the ALU result.
  assign res_data_nxt = mem_to_reg_nxt ? alu_data_nxt : mem_data_nxt;

  // Forwarding entry registered alongside wb_we so it mirrors the WRITE cycle
  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= 5'd0;
      fwd_data  <= 32'd0;
    end else begin
      fwd_valid <= wb_we_nxt;
      if (wb_we_nxt) begin
        fwd_addr <= res_addr_nxt;
        fwd_data <= res_data_nxt;
      end
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with randomized stimulus and directed corner cases
`timescale 1ns/1ps
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_all;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        wb_we;
  logic        wb_reg_dst;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_imm_addr;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_alu_data;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        load_wait;

  wb_stage_if bus();

  wb_stage dut (
    .clk           (clk),
    .rst_all       (rst_all),
    .up            (bus),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .flush         (flush),
    .wb_we         (wb_we),
    .wb_reg_dst    (wb_reg_dst),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_imm_addr   (wb_imm_addr),
    .wb_reg_addr   (wb_reg_addr),
    .wb_mem_data   (wb_mem_data),
    .wb_alu_data   (wb_alu_data),
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
    .load_wait     (load_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        reg_dst;
    logic        mem_to_reg;
    logic [4:0]  imm_addr;
    logic [4:0]  reg_addr;
    logic [31:0] mem_data;
    logic [31:0] alu_data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_w;
  wr_t         m_pend;
  bit          m_wait   = 1'b0;
  bit          checking = 1'b0;
  bit          exp_w;
  int          n_pass   = 0;
  int          n_total  = 0;
  logic [31:0] rf [32]  = '{default: 32'd0};
  logic [4:0]  dut_addr;
  logic [31:0] dut_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic wr_t mk(input logic rdst, input logic m2r, input logic [4:0] ia,
                             input logic [4:0] ra, input logic [31:0] md, input logic [31:0] ad);
    wr_t w;
    w.reg_dst    = rdst;
    w.mem_to_reg = m2r;
    w.imm_addr   = ia;
    w.reg_addr   = ra;
    w.mem_data   = md;
    w.alu_data   = ad;
    w.addr       = rdst ? ra : ia;
    w.data       = m2r ? ad : md;
    return w;
  endfunction

  // One cycle of stimulus; the model predicts the effect of the coming edge.
  task automatic step(input logic v, input logic we, input logic ld, input logic rdst,
                      input logic m2r, input logic [4:0] ia, input logic [4:0] ra,
                      input logic [31:0] ad, input logic rv, input logic [31:0] rd,
                      input logic fl);
    wr_t w;
    @(negedge clk);
    #1;
    bus.valid      = v;
    bus.we         = we;
    bus.is_load    = ld;
    bus.reg_dst    = rdst;
    bus.mem_to_reg = m2r;
    bus.imm_addr   = ia;
    bus.reg_addr   = ra;
    bus.alu_data   = ad;
    mem_rvalid     = rv;
    mem_rdata      = rd;
    flush          = fl;
    if (rst_all) begin
      if (fl) begin
        m_wait = 1'b0;
      end else if (m_wait) begin
        if (rv) begin
          w = mk(m_pend.reg_dst, m_pend.mem_to_reg, m_pend.imm_addr, m_pend.reg_addr, rd, m_pend.alu_data);
          if (w.addr != 5'd0) exp_q.push_back(w);
          m_wait = 1'b0;
        end
      end else if (v) begin
        w = mk(rdst, m2r, ia, ra, 32'd0, ad);
        if (we && ld) begin
          m_pend = w;
          m_wait = 1'b1;
        end else if (we && w.addr != 5'd0) begin
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a, 5'd0, d, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic ld(input logic [4:0] a);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, a, 32'hDEAD0000, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rvalid(input logic [31:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b1, d, 1'b0);
  endtask

  // Monitor: every cycle, the write the model expects must appear exactly now.
  always @(negedge clk) begin
    if (checking) begin
      exp_w = (exp_q.size() != 0);
      if (exp_w) mon_w = exp_q.pop_front();
      chk("in_ready", 32'(bus.ready), 32'(!m_wait));
      chk("load_wait", 32'(load_wait), 32'(m_wait));
      chk("wb_we", 32'(wb_we), 32'(exp_w));
      if (exp_w) begin
        chk("wb_reg_dst", 32'(wb_reg_dst), 32'(mon_w.reg_dst));
        chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(mon_w.mem_to_reg));
        chk("wb_imm_addr", 32'(wb_imm_addr), 32'(mon_w.imm_addr));
        chk("wb_reg_addr", 32'(wb_reg_addr), 32'(mon_w.reg_addr));
        chk("wb_mem_data", wb_mem_data, mon_w.mem_data);
        chk("wb_alu_data", wb_alu_data, mon_w.alu_data);
      end
`ifdef WB_FWD_EN
      chk("fwd_valid", 32'(fwd_valid), 32'(exp_w));
      if (exp_w) begin
        chk("fwd_addr", 32'(fwd_addr), 32'(mon_w.addr));
        chk("fwd_data", fwd_data, mon_w.data);
      end
`else
      chk("fwd_valid_tied", 32'(fwd_valid), 32'd0);
      chk("fwd_addr_tied", 32'(fwd_addr), 32'd0);
      chk("fwd_data_tied", fwd_data, 32'd0);
`endif
      // Emulated register file fed from the DUT's write port.
      dut_addr = wb_reg_dst ? wb_reg_addr : wb_imm_addr;
      dut_data = wb_mem_to_reg ? wb_alu_data : wb_mem_data;
      if (wb_we === 1'b1 && dut_addr != 5'd0) rf[dut_addr] = dut_data;
    end
  end

  initial begin
    // Reset held with arbitrary inputs active.
    rst_all        = 1'b0;
    bus.valid      = 1'b1;
    bus.we         = 1'b1;
    bus.is_load    = 1'b0;
    bus.reg_dst    = 1'b1;
    bus.mem_to_reg = 1'b1;
    bus.imm_addr   = 5'd3;
    bus.reg_addr   = 5'd7;
    bus.alu_data   = 32'hFFFF_FFFF;
    mem_rvalid     = 1'b1;
    mem_rdata      = 32'h1234_5678;
    flush          = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_reg_dst", 32'(wb_reg_dst), 32'd0);
    chk("rst_wb_mem_to_reg", 32'(wb_mem_to_reg), 32'd0);
    chk("rst_wb_imm_addr", 32'(wb_imm_addr), 32'd0);
    chk("rst_wb_reg_addr", 32'(wb_reg_addr), 32'd0);
    chk("rst_wb_mem_data", wb_mem_data, 32'd0);
    chk("rst_wb_alu_data", wb_alu_data, 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_fwd_addr", 32'(fwd_addr), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    chk("rst_in_ready", 32'(bus.ready), 32'd1);
    chk("rst_load_wait", 32'(load_wait), 32'd0);
    #1;
    bus.valid  = 1'b0;
    mem_rvalid = 1'b0;
    rst_all    = 1'b1;
    m_wait     = 1'b0;
    checking   = 1'b1;

    // Non-load write to register 1.
    wr(5'd1, 32'h5ADFACED);
    idle();
    idle();
    chk("rf_read_1", rf[1], 32'h5ADFACED);

    // Load with three-cycle memory latency; a valid during the wait is ignored.
    ld(5'b10101);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd30, 5'd0, 32'h1111_1111, 1'b0, 32'd0, 1'b0);
    chk("load_in_ready", 32'(bus.ready), 32'd0);
    chk("load_wb_we", 32'(wb_we), 32'd0);
    idle();
    rvalid(32'hEA770A57);
    idle();
    chk("load_wb_mem_data", wb_mem_data, 32'hEA770A57);
    idle();
    chk("rf_read_21", rf[21], 32'hEA770A57);

    // Back-to-back non-load writes to 2..5.
    for (int i = 2; i <= 5; i++) begin
      wr(5'(i), 32'hB0B0_0000 + 32'(i));
      if (i > 2) chk("b2b_in_ready", 32'(bus.ready), 32'd1);
    end
    idle();
    idle();
    for (int i = 2; i <= 5; i++) chk("rf_b2b", rf[i], 32'hB0B0_0000 + 32'(i));

    // Flush during WAIT_MEM, then a late mem_rvalid must not write.
    ld(5'd7);
    idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    rvalid(32'hBAD0_0007);
    chk("flush_load_wait", 32'(load_wait), 32'd0);
    idle();
    idle();
    chk("flush_rf_7", rf[7], 32'd0);

    // Write to register 0 is suppressed.
    wr(5'd0, 32'hCAFE_0000);
    idle();
    chk("r0_wb_we", 32'(wb_we), 32'd0);
    chk("r0_fwd_valid", 32'(fwd_valid), 32'd0);

    // Stray mem_rvalid while EMPTY, then a real load sees only its own data.
    rvalid(32'h5757_5757);
    idle();
    chk("stray_load_wait", 32'(load_wait), 32'd0);
    ld(5'd12);
    rvalid(32'h0C0C_0C0C);
    idle();
    idle();
    chk("rf_read_12", rf[12], 32'h0C0C_0C0C);

    // Asynchronous reset in the middle of WAIT_MEM.
    ld(5'd9);
    idle();
    chk("areset_pre_wait", 32'(load_wait), 32'd1);
    #2;
    rst_all = 1'b0;
    m_wait  = 1'b0;
    exp_q.delete();
    #1;
    chk("areset_load_wait", 32'(load_wait), 32'd0);
    chk("areset_in_ready", 32'(bus.ready), 32'd1);
    chk("areset_wb_we", 32'(wb_we), 32'd0);
    chk("areset_fwd_valid", 32'(fwd_valid), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_all = 1'b1;
    rvalid(32'h9999_9999);
    idle();
    idle();
    chk("areset_rf_9", rf[9], 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 3,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
           $urandom,
           $urandom_range(0, 9) < 4,
           $urandom,
           $urandom_range(0, 19) == 0);
    end
    idle();
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
